// File: rtl/sr_data_mem_if.sv
// rtl/sr_data_mem_if.sv - CPU data-port address and store-strobe bundle
interface sr_data_mem_if;
    logic [31:0] memAddr;
    logic        memWriteEnable;

    modport master (output memAddr, output memWriteEnable);
    modport slave  (input  memAddr, input  memWriteEnable);
endinterface

// File: rtl/sr_data_mem.sv
// rtl/sr_data_mem.sv - data RAM plus GPIO/timer MMIO responder for the CPU memory port
// The compare timer is built only when SR_DMEM_TIMER_EN is defined.
module sr_data_mem #(
    parameter int RAM_AW = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_data_mem_if.slave        bus,
    inout  wire  [31:0]         memData,
    input  logic [31:0]         gpioIn,
    output logic [31:0]         gpioOut,
    output logic                timerIrq
);
    localparam logic [7:0] OFF_GPIO_OUT   = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN    = 8'h04;
    localparam logic [7:0] OFF_TIMER_CNT  = 8'h08;
    localparam logic [7:0] OFF_TIMER_CMP  = 8'h0C;
    localparam logic [7:0] OFF_TIMER_CTRL = 8'h10;
    localparam logic [7:0] OFF_TIMER_STAT = 8'h14;

    logic [31:0]       ram [0:(1 << RAM_AW) - 1];
    logic [31:0]       rdData;
    logic [31:0]       wrData;
    logic              isMmio;
    logic              ramWrite;
    logic              mmioWrite;
    logic [RAM_AW-1:0] wordIdx;
    logic [7:0]        offset;
    logic [31:0]       gpioSync1;
    logic [31:0]       gpioSync2;
    logic              unusedAddrBits;

    assign wrData         = memData;
    assign isMmio         = bus.memAddr[31];
    assign wordIdx        = bus.memAddr[RAM_AW+1:2];
    assign offset         = bus.memAddr[7:0];
    assign ramWrite       = bus.memWriteEnable && !isMmio;
    assign mmioWrite      = bus.memWriteEnable && isMmio;
    assign unusedAddrBits = ^bus.memAddr[30:8];

    // The CPU owns the bus during stores; otherwise loads are answered combinationally.
    assign memData = bus.memWriteEnable ? 32'bz : rdData;

    // RAM ignores reset so a store in a reset cycle still lands.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            ram[wordIdx] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpioSync1 <= '0;
            gpioSync2 <= '0;
            gpioOut   <= '0;
        end else begin
            gpioSync1 <= gpioIn;
            gpioSync2 <= gpioSync1;
            if (mmioWrite && offset == OFF_GPIO_OUT) begin
                gpioOut <= wrData;
            end
        end
    end

`ifdef SR_DMEM_TIMER_EN
    logic [31:0] timerCnt;
    logic [31:0] timerCmp;
    logic        timerEn;
    logic        timerAutoClr;
    logic        timerMatch;
    logic        timerHit;

    assign timerHit = timerEn && (timerCnt == timerCmp);
    assign timerIrq = timerMatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timerCnt     <= '0;
            timerCmp     <= 32'hFFFF_FFFF;
            timerEn      <= 1'b0;
            timerAutoClr <= 1'b0;
            timerMatch   <= 1'b0;
        end else begin
            if (mmioWrite && offset == OFF_TIMER_CNT) begin
                timerCnt <= wrData;
            end else if (timerHit && timerAutoClr) begin
                timerCnt <= '0;
            end else if (timerEn) begin
                timerCnt <= timerCnt + 32'd1;
            end

            if (mmioWrite && offset == OFF_TIMER_CMP) begin
                timerCmp <= wrData;
            end

            if (mmioWrite && offset == OFF_TIMER_CTRL) begin
                timerEn      <= wrData[0];
                timerAutoClr <= wrData[1];
            end

            // A fresh hit beats a simultaneous write-1-to-clear.
            if (timerHit) begin
                timerMatch <= 1'b1;
            end else if (mmioWrite && offset == OFF_TIMER_STAT && wrData[0]) begin
                timerMatch <= 1'b0;
            end
        end
    end
`else
    assign timerIrq = 1'b0;
`endif

    always_comb begin
        rdData = '0;
        if (!isMmio) begin
            rdData = ram[wordIdx];
        end else begin
            case (offset)
                OFF_GPIO_OUT:   rdData = gpioOut;
                OFF_GPIO_IN:    rdData = gpioSync2;
`ifdef SR_DMEM_TIMER_EN
                OFF_TIMER_CNT:  rdData = timerCnt;
                OFF_TIMER_CMP:  rdData = timerCmp;
                OFF_TIMER_CTRL: rdData = {30'b0, timerAutoClr, timerEn};
                OFF_TIMER_STAT: rdData = {31'b0, timerMatch};
`endif
                default:        rdData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_data_mem.sv
// tb/tb_sr_data_mem.sv - self-checking bench for sr_data_mem against a behavioural model
module tb_sr_data_mem;
`ifdef SR_DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [31:0] CMP_RESET = TIMER ? 32'hFFFF_FFFF : 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpioIn;
    logic [31:0] gpioOut;
    logic        timerIrq;
    logic [31:0] cpuAddr;
    logic [31:0] cpuData;
    logic        cpuWe;
    wire  [31:0] memData;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    sr_data_mem_if bus ();
    assign bus.memAddr        = cpuAddr;
    assign bus.memWriteEnable = cpuWe;
    assign memData            = cpuWe ? cpuData : 32'bz;

    sr_data_mem #(.RAM_AW(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .memData  (memData),
        .gpioIn   (gpioIn),
        .gpioOut  (gpioOut),
        .timerIrq (timerIrq)
    );

    // Behavioural model: architectural register values plus a 2-deep delay line for gpioIn.
    logic [31:0] mRam [64];
    bit          mValid [64];
    logic [31:0] mGpioOut = '0;
    logic [31:0] mGpioDelay [$] = '{32'h0, 32'h0};
    logic [31:0] mCnt = '0;
    logic [31:0] mCmp = CMP_RESET;
    bit          mEn = 1'b0;
    bit          mAuto = 1'b0;
    bit          mMatch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [32:0] modelRead(input logic [31:0] addr);
        if (!addr[31]) return {mValid[addr[7:2]], mRam[addr[7:2]]};
        case (addr[7:0])
            8'h00: return {1'b1, mGpioOut};
            8'h04: return {1'b1, mGpioDelay[0]};
            8'h08: return {1'b1, TIMER ? mCnt : 32'h0};
            8'h0C: return {1'b1, TIMER ? mCmp : 32'h0};
            8'h10: return {1'b1, TIMER ? {30'h0, mAuto, mEn} : 32'h0};
            8'h14: return {1'b1, TIMER ? {31'h0, mMatch} : 32'h0};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit hit;
        bit wr;
        logic [7:0] off;
        logic [31:0] nextCnt;
        started = 1'b1;
        if (cpuWe && !cpuAddr[31]) begin
            mRam[cpuAddr[7:2]]   = cpuData;
            mValid[cpuAddr[7:2]] = 1'b1;
        end
        if (!rst_n) begin
            mGpioOut   = '0;
            mGpioDelay = '{32'h0, 32'h0};
            mCnt = '0; mCmp = CMP_RESET; mEn = 1'b0; mAuto = 1'b0; mMatch = 1'b0;
        end else begin
            wr  = cpuWe && cpuAddr[31];
            off = cpuAddr[7:0];
            if (wr && off == 8'h00) mGpioOut = cpuData;
            mGpioDelay.push_back(gpioIn);
            void'(mGpioDelay.pop_front());
            if (TIMER) begin
                hit = mEn && (mCnt == mCmp);
                if (wr && off == 8'h08)  nextCnt = cpuData;
                else if (hit && mAuto)   nextCnt = 32'h0;
                else if (mEn)            nextCnt = mCnt + 32'd1;
                else                     nextCnt = mCnt;
                if (hit) mMatch = 1'b1;
                else if (wr && off == 8'h14 && cpuData[0]) mMatch = 1'b0;
                if (wr && off == 8'h0C) mCmp = cpuData;
                if (wr && off == 8'h10) begin mEn = cpuData[0]; mAuto = cpuData[1]; end
                mCnt = nextCnt;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [32:0] r;
        if (started) begin
            if (cpuWe) check("busCpuDriven", memData, cpuData);
            else begin
                r = modelRead(cpuAddr);
                if (r[32]) check("modelLoad", memData, r[31:0]);
            end
            check("modelGpioOut", gpioOut, mGpioOut);
            check("modelTimerIrq", {31'h0, timerIrq}, {31'h0, mMatch});
        end
    end

    task automatic setBus(input bit we, input logic [31:0] addr, input logic [31:0] data);
        cpuWe = we; cpuAddr = addr; cpuData = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input bit we, input logic [31:0] addr, input logic [31:0] data);
        setBus(we, addr, data);
        tick();
    endtask

    task automatic loadExpect(input string name, input logic [31:0] addr, input logic [31:0] exp);
        setBus(1'b0, addr, 32'h0);
        check(name, memData, exp);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] cntSeq [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        logic [31:0] irqSeq [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        rst_n = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuData = '0; gpioIn = '0;
        #2;
        tick(); tick();
        rst_n = 1'b1;

        check("resetGpioOut", gpioOut, 32'h0);
        check("resetTimerIrq", {31'h0, timerIrq}, 32'h0);
        loadExpect("resetGpioOutReg", 32'h8000_0000, 32'h0);
        loadExpect("resetCmp", 32'h8000_000C, CMP_RESET);
        loadExpect("resetGpioIn", 32'h8000_0004, 32'h0);

        cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        loadExpect("ramLoad", 32'h0000_0010, 32'hDEAD_BEEF);
        loadExpect("ramAlias", 32'h0000_0110, 32'hDEAD_BEEF);

        setBus(1'b1, 32'h0000_0040, 32'h1234_5678);
        check("busCpuValue", memData, 32'h1234_5678);
        tick();
        loadExpect("busBlockDrives", 32'h0000_0040, 32'h1234_5678);

        cyc(1'b1, 32'h8000_0000, 32'h0000_00A5);
        check("gpioOutStore", gpioOut, 32'h0000_00A5);
        cyc(1'b1, 32'h8000_0004, 32'hFFFF_FFFF);
        loadExpect("unmappedRead", 32'h8000_0018, 32'h0);

        gpioIn = 32'h1234_5678;
        loadExpect("gpioInCycle0", 32'h8000_0004, 32'h0);
        loadExpect("gpioInCycle1", 32'h8000_0004, 32'h0);
        loadExpect("gpioInCycle2", 32'h8000_0004, 32'h1234_5678);

        cyc(1'b1, 32'h8000_000C, 32'd5);
        cyc(1'b1, 32'h8000_0010, 32'h3);
`ifdef SR_DMEM_TIMER_EN
        for (int i = 0; i < 8; i++) begin
            setBus(1'b0, 32'h8000_0008, 32'h0);
            check($sformatf("autoClrCnt%0d", i), memData, cntSeq[i]);
            check($sformatf("autoClrIrq%0d", i), {31'h0, timerIrq}, irqSeq[i]);
            tick();
        end
        cyc(1'b1, 32'h8000_0014, 32'h1);
        check("w1cClears", {31'h0, timerIrq}, 32'h0);
        loadExpect("cntAfterClear", 32'h8000_0008, 32'd3);
        loadExpect("cntBeforeHit", 32'h8000_0008, 32'd4);
        cyc(1'b1, 32'h8000_0014, 32'h1);
        check("setBeatsClear", {31'h0, timerIrq}, 32'h1);
        loadExpect("cntAfterAutoClr", 32'h8000_0008, 32'd0);

        cyc(1'b1, 32'h8000_0010, 32'h1);
        loadExpect("ctrlReadback", 32'h8000_0010, 32'h1);
        cyc(1'b1, 32'h8000_0008, 32'hFFFF_FFFE);
        loadExpect("wrapPre", 32'h8000_0008, 32'hFFFF_FFFE);
        loadExpect("wrapMax", 32'h8000_0008, 32'hFFFF_FFFF);
        loadExpect("wrapZero", 32'h8000_0008, 32'h0);
        cyc(1'b1, 32'h8000_0008, 32'd7);
        loadExpect("cntWritePriority", 32'h8000_0008, 32'd7);
        loadExpect("cntAfterWrite", 32'h8000_0008, 32'd8);
`else
        loadExpect("noTimerCnt", 32'h8000_0008, 32'h0);
        loadExpect("noTimerCmp", 32'h8000_000C, 32'h0);
        loadExpect("noTimerCtrl", 32'h8000_0010, 32'h0);
        loadExpect("noTimerStat", 32'h8000_0014, 32'h0);
        check("noTimerIrq", {31'h0, timerIrq}, 32'h0);
`endif

        rst_n = 1'b0;
        cyc(1'b1, 32'h0000_0080, 32'h0BAD_F00D);
        cyc(1'b1, 32'h8000_0000, 32'h0000_00FF);
        rst_n = 1'b1;
        check("rstGpioOut", gpioOut, 32'h0);
        check("rstTimerIrq", {31'h0, timerIrq}, 32'h0);
        loadExpect("rstGpioIn", 32'h8000_0004, 32'h0);
        loadExpect("rstCnt", 32'h8000_0008, 32'h0);
        loadExpect("rstCmp", 32'h8000_000C, CMP_RESET);
        loadExpect("rstCtrl", 32'h8000_0010, 32'h0);
        loadExpect("rstStat", 32'h8000_0014, 32'h0);
        loadExpect("rstGpioOutReg", 32'h8000_0000, 32'h0);
        loadExpect("rstRamKept", 32'h0000_0010, 32'hDEAD_BEEF);
        loadExpect("rstRamStore", 32'h0000_0080, 32'h0BAD_F00D);

        cpuWe = 1'b0;
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sr_data_mem.md
# sr_data_mem

- Data-side responder for the CPU's memory port (`memAddr`, `memWriteEnable`, `memData`).
- Contains a word-addressed data RAM and a small memory-mapped I/O bank: GPIO and an optional compare timer.
- Answers loads combinationally so the CPU's memory-access stage can capture `memData` in the same cycle.
- Commits stores on the rising clock edge.

## Interface
Parameters:
- `RAM_AW`, 6, RAM word-address width; depth is 2^RAM_AW words.

Ports:
- `clk`, input, 1, clock.
- `rst_n`, input, 1, reset; synchronous, active-low.
- `memAddr`, input, 32, byte address from the CPU.
- `memWriteEnable`, input, 1, store strobe for the current cycle.
- `memData`, inout, 32, bidirectional data bus.
  - The CPU drives it while `memWriteEnable`=1.
  - This block drives read data while `memWriteEnable`=0, otherwise it drives `'z`.
- `gpioIn`, input, 32, asynchronous external inputs.
- `gpioOut`, output, 32, GPIO output register.
- `timerIrq`, output, 1, timer match flag.

## Operation
Address decode:
- `memAddr[31]`=0 selects RAM. The word index is `memAddr[RAM_AW+1:2]`.
  - Upper bits are ignored, so the RAM aliases across the region.
  - `memAddr[1:0]` is ignored; all accesses are whole-word.
- `memAddr[31]`=1 selects MMIO. The offset is `memAddr[7:0]`, and only word offsets are decoded.

RAM behaviour:
- Read is asynchronous.
- Write occurs at posedge when `memWriteEnable`=1.
- Contents are not affected by reset.

MMIO map (offset, access, reset value):
- 0x00 GPIO_OUT, RW, 0. Drives `gpioOut`.
- 0x04 GPIO_IN, RO. Returns `gpioIn` after a 2-flop synchronizer; the synchronizer flops reset to 0.
- 0x08 TIMER_CNT, RW, 0.
- 0x0C TIMER_CMP, RW, 0xFFFF_FFFF.
- 0x10 TIMER_CTRL, RW, 0. Bit0 `en`, bit1 `autoClr`; bits 31:2 read 0.
- 0x14 TIMER_STAT, read / write-1-to-clear, 0. Bit0 `match`; other bits read 0.
- Unmapped MMIO offsets read 0; writes to them are ignored. Writes to GPIO_IN are ignored.

Timer, evaluated each cycle:
- `hit` = `en` && (CNT == CMP).
- Next CNT, in priority order:
  1. CPU write to CNT: loads the written data.
  2. `hit` && `autoClr`: 0.
  3. `en`: CNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
  4. Otherwise: hold.
- `match` becomes 1 on `hit`, and becomes 0 on a STAT write with data bit0=1.
  - If set and clear occur in the same cycle, set wins.
- `timerIrq` = `match`, registered.

## Timing
- Read latency is 0 cycles: `memData` reflects `memAddr` combinationally while `memWriteEnable`=0, including during reset.
- Writes take effect at the posedge where `memWriteEnable`=1. A read of the same address in the following cycle returns the new value.
- GPIO_IN reflects a `gpioIn` change 2 posedges later.
- `gpioOut` and `timerIrq` change only at posedge (registered outputs).
- `hit` uses the pre-edge CNT, so `match` rises at the edge where CNT was equal to CMP.
- Reset with `rst_n`=0 at a posedge:
  - Returns every MMIO register and synchronizer flop to its reset value.
  - Forces `gpioOut`=0 and `timerIrq`=0.
  - Any store in that cycle is dropped for MMIO but still written to RAM.
- No handshake and no wait states: every access completes in its cycle.

## Configuration
- `SR_DMEM_TIMER_EN` defined:
  - The timer is built, with CNT, CMP, CTRL and STAT behaving as described above.
- `SR_DMEM_TIMER_EN` undefined:
  - No timer logic is built.
  - Offsets 0x08–0x14 read 0 and ignore writes.
  - `timerIrq` is tied to 0.
  - RAM and GPIO behaviour is unchanged.

## Test plan
- RAM store/load:
  - Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 next cycle → `memData`=0xDEADBEEF.
  - Load 0x0000_0110 with RAM_AW=6 → 0xDEADBEEF (alias).
- Bus direction:
  - `memWriteEnable`=1 → block output is `'z`, and `memData` equals the CPU-driven value.
  - `memWriteEnable`=0 → block drives the read data.
- GPIO:
  - Store 0x0000_00A5 to 0x8000_0000 → `gpioOut`=0x0000_00A5 after the edge.
  - Set `gpioIn`=0x1234_5678 → a load of 0x8000_0004 returns it on the 2nd cycle after the change, not the 1st.
- Timer match and auto-clear (with `SR_DMEM_TIMER_EN`):
  - Program CMP=5 and CTRL=0x3 → CNT counts 0..5 then 0.
  - `timerIrq` rises the edge after CNT=5.
  - Storing 1 to 0x8000_0014 clears it unless a new hit occurs in the same cycle.
- Wrap and write priority:
  - CNT=0xFFFF_FFFE with `en`=1 → CNT reads 0xFFFF_FFFF, then 0.
  - A CNT write of 7 in a counting cycle → CNT reads 7 next cycle.
- Reset mid-operation:
  - Assert `rst_n`=0 for 1 edge while counting and `gpioOut`≠0 → all MMIO registers and outputs return to reset values.
  - RAM word 0x10 still reads 0xDEADBEEF.
